// File: rtl/rooth_irq_arb.sv
// rooth_irq_arb: pending/mask interrupt arbiter with fixed priority and req/ack/done handshake to the rooth core
module rooth_irq_arb #(
    parameter int INT_NUM   = 8,
    parameter int CPU_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [INT_NUM-1:0]         int_flag_i,
    input  logic                       cfg_we_i,
    input  logic [1:0]                 cfg_addr_i,
    input  logic [CPU_WIDTH-1:0]       cfg_wdata_i,
    output logic [CPU_WIDTH-1:0]       cfg_rdata_o,
    output logic                       int_req_o,
    output logic [$clog2(INT_NUM)-1:0] int_id_o,
    input  logic                       int_ack_i,
    input  logic                       int_done_i,
    output logic                       int_busy_o
);
    localparam int IW = $clog2(INT_NUM);
    typedef enum logic [1:0] {IDLE, REQ, SERVE} state_t;
    state_t state;
    logic [INT_NUM-1:0] mask, edge_q, pend, flag_q, pend_n, hit, rise, clr;
    logic [IW-1:0] low;
    logic ack_ok, unused_wdata;
    assign unused_wdata = ^cfg_wdata_i[CPU_WIDTH-1:INT_NUM];
    assign hit = pend & mask;
    assign rise = int_flag_i & ~flag_q;
    assign ack_ok = state == REQ && int_ack_i;
    assign clr = (cfg_we_i && cfg_addr_i == 2'd1 ? cfg_wdata_i[INT_NUM-1:0] : '0)
               | (ack_ok ? INT_NUM'(1) << int_id_o : '0);
    // edge bits: a new rising edge beats any clear in the same cycle; level bits track the line
    assign pend_n = (edge_q & (rise | (pend & ~clr))) | (~edge_q & int_flag_i);
    assign int_busy_o = state != IDLE;
    assign cfg_rdata_o = cfg_addr_i == 2'd0 ? CPU_WIDTH'(mask)
                       : cfg_addr_i == 2'd1 ? CPU_WIDTH'(pend)
                       : cfg_addr_i == 2'd2 ? CPU_WIDTH'({int_id_o, 2'b00, state == SERVE, int_req_o})
                       : CPU_WIDTH'(edge_q);
    always_comb begin
        low = '0;
        for (int i = INT_NUM - 1; i >= 0; i--)
            if (hit[i]) low = IW'(i);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            int_req_o <= 1'b0;
            int_id_o  <= '0;
            mask      <= '0;
            edge_q    <= '0;
            pend      <= '0;
            flag_q    <= '0;
        end else begin
            flag_q <= int_flag_i;
            pend   <= pend_n;
            if (cfg_we_i && cfg_addr_i == 2'd0) mask <= cfg_wdata_i[INT_NUM-1:0];
            if (cfg_we_i && cfg_addr_i == 2'd3) edge_q <= cfg_wdata_i[INT_NUM-1:0];
            unique case (state)
                IDLE: if (|hit) begin
                    int_id_o  <= low;
                    int_req_o <= 1'b1;
                    state     <= REQ;
                end
                REQ: if (int_ack_i) begin
                    int_req_o <= 1'b0;
                    state     <= SERVE;
                end else if (!mask[int_id_o] || !pend[int_id_o]) begin
                    int_req_o <= 1'b0;
                    state     <= IDLE;
                end
                SERVE: if (int_done_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rooth_irq_arb.sv
// tb_rooth_irq_arb: directed checks of pending, priority, handshake, retract and reset behaviour
module tb_rooth_irq_arb;
    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] int_flag = '0;
    logic cfg_we = 1'b0;
    logic [1:0] cfg_addr = '0;
    logic [31:0] cfg_wdata = '0, cfg_rdata;
    logic int_req, int_ack = 1'b0, int_done = 1'b0, int_busy;
    logic [2:0] int_id;
    int n_cmp = 0, n_err = 0;
    always #5 clk = ~clk;
    rooth_irq_arb dut (
        .clk(clk), .rst(rst), .int_flag_i(int_flag), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
        .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(cfg_rdata), .int_req_o(int_req), .int_id_o(int_id),
        .int_ack_i(int_ack), .int_done_i(int_done), .int_busy_o(int_busy)
    );
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask
    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        cfg_addr = a;
        #1;
        check(tag, cfg_rdata, exp);
    endtask
    task automatic pulse_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask
    task automatic pulse_done();
        int_done = 1'b1;
        tick();
        int_done = 1'b0;
    endtask
    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_req", int_req, 0);
        check("rst_id", int_id, 0);
        check("rst_busy", int_busy, 0);
        rd(0, 0, "rst_mask");
        rd(1, 0, "rst_pend");
        rd(2, 0, "rst_stat");
        rd(3, 0, "rst_edge");
        // single edge source
        wr(3, 32'h08);
        wr(0, 32'h08);
        rd(3, 32'h08, "edge_reg");
        int_flag = 8'h08;
        tick();
        int_flag = 8'h00;
        rd(1, 32'h08, "edge_pend_n1");
        check("edge_req_n1", int_req, 0);
        tick();
        check("edge_req_n2", int_req, 1);
        check("edge_id_n2", int_id, 3);
        check("edge_busy", int_busy, 1);
        rd(2, 32'h31, "edge_stat_req");
        pulse_ack();
        check("edge_req_after_ack", int_req, 0);
        rd(1, 32'h00, "edge_pend_cleared");
        rd(2, 32'h32, "edge_stat_serve");
        pulse_done();
        check("edge_idle", int_busy, 0);
        tick();
        tick();
        check("edge_no_rereq", int_req, 0);
        // priority
        wr(3, 32'hFF);
        wr(0, 32'hFF);
        int_flag = 8'h24;
        tick();
        int_flag = 8'h00;
        rd(1, 32'h24, "prio_pend");
        tick();
        check("prio_req", int_req, 1);
        check("prio_id2", int_id, 2);
        pulse_ack();
        rd(1, 32'h20, "prio_pend_serve2");
        pulse_done();
        check("prio_m1_req", int_req, 0);
        check("prio_m1_busy", int_busy, 0);
        tick();
        check("prio_m2_req", int_req, 1);
        check("prio_id5", int_id, 5);
        pulse_ack();
        pulse_done();
        // level mode
        wr(3, 32'h00);
        wr(0, 32'h01);
        int_flag = 8'h01;
        tick();
        tick();
        check("lvl_req", int_req, 1);
        check("lvl_id", int_id, 0);
        pulse_ack();
        rd(1, 32'h01, "lvl_pend_after_ack");
        pulse_done();
        check("lvl_m1_req", int_req, 0);
        tick();
        check("lvl_rereq", int_req, 1);
        check("lvl_rereq_id", int_id, 0);
        pulse_ack();
        int_flag = 8'h00;
        tick();
        pulse_done();
        tick();
        tick();
        check("lvl_no_rereq", int_req, 0);
        check("lvl_idle", int_busy, 0);
        // retract and masking
        wr(3, 32'h10);
        wr(0, 32'h00);
        int_flag = 8'h10;
        tick();
        int_flag = 8'h00;
        tick();
        tick();
        check("mask_off_req", int_req, 0);
        rd(1, 32'h10, "mask_off_pend");
        wr(0, 32'h10);
        tick();
        check("ret_req", int_req, 1);
        check("ret_id", int_id, 4);
        wr(0, 32'h00);
        tick();
        check("ret_req_low", int_req, 0);
        check("ret_idle", int_busy, 0);
        wr(0, 32'h10);
        tick();
        check("ackwin_req", int_req, 1);
        wr(0, 32'h00);
        pulse_ack();
        check("ackwin_req_low", int_req, 0);
        check("ackwin_busy", int_busy, 1);
        rd(2, 32'h42, "ackwin_stat");
        rd(1, 32'h00, "ackwin_pend");
        pulse_done();
        // write-1-to-clear racing a new edge
        wr(3, 32'h02);
        int_flag = 8'h02;
        cfg_we = 1'b1;
        cfg_addr = 2'd1;
        cfg_wdata = 32'h02;
        tick();
        cfg_we = 1'b0;
        rd(1, 32'h02, "race_set_wins");
        int_flag = 8'h00;
        wr(1, 32'h02);
        rd(1, 32'h00, "w1c");
        // reset mid-service
        wr(3, 32'h40);
        wr(0, 32'h40);
        int_flag = 8'h40;
        tick();
        int_flag = 8'h00;
        tick();
        check("rs_id_req", int_id, 6);
        pulse_ack();
        check("rs_serve", int_busy, 1);
        rst = 1'b1;
        int_done = 1'b1;
        tick();
        rst = 1'b0;
        int_done = 1'b0;
        check("rs_req", int_req, 0);
        check("rs_id", int_id, 0);
        check("rs_busy", int_busy, 0);
        rd(0, 0, "rs_mask");
        rd(1, 0, "rs_pend");
        rd(3, 0, "rs_edge");
        int_flag = 8'h40;
        tick();
        int_flag = 8'h00;
        tick();
        tick();
        check("rs_ignored", int_req, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
